// File: rtl/lei_xbar_pkg.sv
// Shared types and helpers for the lei_xbar input crossbar.
// Optional parity framing is selected with LEI_XBAR_PARITY_EN.
package lei_xbar_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} lei_xbar_state_t;

    function automatic int sel_width(input int num_src);
        return $clog2(num_src + 1);
    endfunction

endpackage

// File: rtl/lei_xbar_cfg_chain.sv
// Serial config staging register with saturating bit counter and frame check.
// LEI_XBAR_PARITY_EN appends an even-parity bit to every frame.
module lei_xbar_cfg_chain #(
    parameter int CFG_BITS = 48
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                shift,
    input  logic                clr,
    input  logic                config_data_in,
    output logic                config_data_out,
    output logic                frame_ok,
    output logic [CFG_BITS-1:0] cfg_word
);

`ifdef LEI_XBAR_PARITY_EN
    localparam int FRAME = CFG_BITS + 1;
`else
    localparam int FRAME = CFG_BITS;
`endif
    localparam int CNT_W = $clog2(FRAME + 1);

    logic [FRAME-1:0] staging;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            staging <= '0;
            cnt     <= '0;
        end else begin
            if (shift) begin
                staging <= {staging[FRAME-2:0], config_data_in};
            end
            if (clr) begin
                cnt <= '0;
            end else if (shift && cnt != CNT_W'(FRAME)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Config fields are the first CFG_BITS bits shifted; a parity bit trails them.
    assign cfg_word        = staging[FRAME-1 -: CFG_BITS];
    assign config_data_out = staging[FRAME-1];

`ifdef LEI_XBAR_PARITY_EN
    assign frame_ok = (cnt == CNT_W'(FRAME)) && !(^staging);
`else
    assign frame_ok = (cnt == CNT_W'(FRAME));
`endif

endmodule

// File: rtl/lei_xbar.sv
// Double-buffered LE input crossbar: staged serial config, atomic commit.
// Build with LEI_XBAR_PARITY_EN to require an even-parity bit per frame.
module lei_xbar
    import lei_xbar_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int NUM_DST   = 4,
    parameter int LE_INPUTS = 4
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         en,
    input  logic                         config_en,
    input  logic                         config_data_in,
    output logic                         config_data_out,
    input  logic [NUM_SRC-1:0]           leout,
    output logic [NUM_DST*LE_INPUTS-1:0] lein,
    output logic [NUM_DST*LE_INPUTS-1:0] drv,
    output logic                         cfg_done,
    output logic                         cfg_err
);

    localparam int SEL_W    = sel_width(NUM_SRC);
    localparam int CFG_BITS = NUM_DST * LE_INPUTS * SEL_W;

    lei_xbar_state_t     state;
    lei_xbar_state_t     next_state;
    logic [CFG_BITS-1:0] active;
    logic [CFG_BITS-1:0] cfg_word;
    logic                frame_ok;
    logic                shift;
    logic                clr;
    logic [SEL_W-1:0]    sel;

    assign shift = en && config_en && (state != COMMIT);
    assign clr   = (state == COMMIT);

    lei_xbar_cfg_chain #(
        .CFG_BITS(CFG_BITS)
    ) u_chain (
        .clk            (clk),
        .nrst           (nrst),
        .shift          (shift),
        .clr            (clr),
        .config_data_in (config_data_in),
        .config_data_out(config_data_out),
        .frame_ok       (frame_ok),
        .cfg_word       (cfg_word)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (config_en) next_state = LOAD;
            LOAD:    if (!config_en) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            active   <= '1;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            if (state == COMMIT) begin
                if (frame_ok) begin
                    active   <= cfg_word;
                    cfg_done <= 1'b1;
                    cfg_err  <= 1'b0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

    // Out-of-range selects leave the input undriven and low.
    always_comb begin
        lein = '0;
        drv  = '0;
        sel  = '0;
        for (int d = 0; d < NUM_DST; d++) begin
            for (int j = 0; j < LE_INPUTS; j++) begin
                sel = active[((j*NUM_DST)+d)*SEL_W +: SEL_W];
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (sel == SEL_W'(s)) begin
                        lein[d*LE_INPUTS+j] = leout[s];
                        drv[d*LE_INPUTS+j]  = 1'b1;
                    end
                end
            end
        end
    end

endmodule
